// File: rtl/univ_reg.sv
// -----------------------------------------------------------------------------
// univ_reg -- universal register: parallel load, shift, rotate, increment and
// decrement, all clocked on the falling edge of CLKb.
//
// Parameters
//   WIDTH    register width in bits (2..32)
//   RST_VAL  value loaded into Q by a synchronous reset
//
// Ports
//   CLKb  in   clock; every state update happens on its falling edge
//   RST   in   synchronous active-high reset (beats EN and MODE)
//   EN    in   operation enable; 0 holds all state
//   MODE  in   [2:0] operation select (see mode_e)
//   D     in   [WIDTH-1:0] parallel load data
//   SIN   in   serial input for SHL/SHR
//   Q     out  [WIDTH-1:0] register contents
//   Qb    out  [WIDTH-1:0] registered complement of Q
//   SOUT  out  bit moved out by the last shift/rotate (registered)
//   CO    out  carry/borrow of the last enabled operation (registered)
//   ZERO  out  Q == 0, combinational from Q
// -----------------------------------------------------------------------------
module univ_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLKb,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             SOUT,
  output logic             CO,
  output logic             ZERO
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("univ_reg: WIDTH must be in 2..32");
  end

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qb_q;
  logic             sout_q, sout_d;
  logic             co_q, co_d;

  // Next-state for an enabled, non-reset edge.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case can leave one unassigned and infer a latch.
    q_d    = q_q;
    sout_d = sout_q;
    co_d   = 1'b0;   // only INC/DEC can raise the flag; every other op clears it
    unique case (mode_e'(MODE))
      MODE_HOLD: ;
      MODE_LOAD: q_d = D;
      MODE_SHL: begin
        q_d    = {q_q[WIDTH-2:0], SIN};
        sout_d = q_q[WIDTH-1];
      end
      MODE_SHR: begin
        q_d    = {SIN, q_q[WIDTH-1:1]};
        sout_d = q_q[0];
      end
      MODE_ROL: begin
        q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        sout_d = q_q[WIDTH-1];
      end
      MODE_ROR: begin
        q_d    = {q_q[0], q_q[WIDTH-1:1]};
        sout_d = q_q[0];
      end
      MODE_INC: begin
        q_d  = q_q + WIDTH'(1);
        co_d = &q_q;    // wrap from all ones to zero
      end
      MODE_DEC: begin
        q_d  = q_q - WIDTH'(1);
        co_d = ~|q_q;   // borrow from zero to all ones
      end
      default: ;
    endcase
  end

  // State register on the falling edge. Qb is loaded from the same next
  // value as Q, so the pair is complementary after every edge, reset included.
  always_ff @(negedge CLKb) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    if (RST) begin
      q_q    <= RST_VAL;
      qb_q   <= ~RST_VAL;
      sout_q <= 1'b0;
      co_q   <= 1'b0;
    end else if (EN) begin
      q_q    <= q_d;
      qb_q   <= ~q_d;
      sout_q <= sout_d;
      co_q   <= co_d;
    end
  end

  assign Q    = q_q;
  assign Qb   = qb_q;
  assign SOUT = sout_q;
  assign CO   = co_q;
  assign ZERO = ~|q_q;

endmodule

// File: tb/tb_univ_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_reg -- directed and random checks of univ_reg (WIDTH=8).
// dut0 uses RST_VAL=0, dut1 uses RST_VAL=0x10; both share the same inputs.
// Inputs change one time unit after a falling edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_univ_reg;

  localparam logic [2:0] M_HOLD = 3'b000, M_LOAD = 3'b001, M_SHL = 3'b010,
                         M_SHR  = 3'b011, M_ROL  = 3'b100, M_ROR = 3'b101,
                         M_INC  = 3'b110, M_DEC  = 3'b111;

  logic       clkb = 1'b1;
  logic       rst  = 1'b0;
  logic       en   = 1'b0;
  logic [2:0] mode = M_HOLD;
  logic [7:0] d    = 8'h00;
  logic       sin  = 1'b0;

  logic [7:0] q0, qb0, q1, qb1;
  logic       sout0, co0, zero0, sout1, co1, zero1;

  int tests = 0;
  int fails = 0;

  // One directed step: inputs, then expected Q/SOUT/CO after the edge.
  typedef struct packed {
    logic       r;
    logic       e;
    logic [2:0] m;
    logic [7:0] d;
    logic       s;
    logic [7:0] q;
    logic       so;
    logic       co;
  } vec_t;

  univ_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut0 (
    .CLKb(clkb), .RST(rst), .EN(en), .MODE(mode), .D(d), .SIN(sin),
    .Q(q0), .Qb(qb0), .SOUT(sout0), .CO(co0), .ZERO(zero0)
  );

  univ_reg #(.WIDTH(8), .RST_VAL(8'h10)) dut1 (
    .CLKb(clkb), .RST(rst), .EN(en), .MODE(mode), .D(d), .SIN(sin),
    .Q(q1), .Qb(qb1), .SOUT(sout1), .CO(co1), .ZERO(zero1)
  );

  always #5 clkb = ~clkb;

  task automatic drive(input logic r, input logic e, input logic [2:0] m,
                       input logic [7:0] dd, input logic s);
    rst  = r;
    en   = e;
    mode = m;
    d    = dd;
    sin  = s;
    @(negedge clkb);
    #1;
  endtask

  function automatic logic [18:0] obs0();
    return {q0, qb0, sout0, co0, zero0};
  endfunction

  function automatic logic [18:0] obs1();
    return {q1, qb1, sout1, co1, zero1};
  endfunction

  // Full expected output vector {Q, Qb, SOUT, CO, ZERO} from an expected Q.
  function automatic logic [18:0] expv(input logic [7:0] q, input logic so,
                                       input logic co);
    return {q, ~q, so, co, (q == 8'h00)};
  endfunction

  task automatic test_reset_load_hold();
    vec_t v [0:4];
    v = '{
      '{1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
      '{1'b0, 1'b1, M_LOAD, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0},
      '{1'b0, 1'b0, M_INC,  8'hFF, 1'b1, 8'hA5, 1'b0, 1'b0},
      '{1'b0, 1'b0, M_INC,  8'h00, 1'b0, 8'hA5, 1'b0, 1'b0},
      '{1'b0, 1'b0, M_INC,  8'h3C, 1'b1, 8'hA5, 1'b0, 1'b0}
    };
    for (int i = 0; i < 5; i++) begin
      drive(v[i].r, v[i].e, v[i].m, v[i].d, v[i].s);
      tests++;
      if (obs0() !== expv(v[i].q, v[i].so, v[i].co)) begin
        fails++;
        $display("FAIL reset_load_hold[%0d]: got {Q,Qb,SOUT,CO,ZERO}=%h want %h",
                 i, obs0(), expv(v[i].q, v[i].so, v[i].co));
      end
    end
  endtask

  task automatic test_shift_rotate();
    vec_t v [0:7];
    v = '{
      '{1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
      '{1'b0, 1'b1, M_LOAD, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0},
      '{1'b0, 1'b1, M_SHL,  8'h00, 1'b0, 8'h02, 1'b1, 1'b0},
      '{1'b0, 1'b1, M_SHR,  8'h00, 1'b1, 8'h81, 1'b0, 1'b0},
      '{1'b0, 1'b1, M_ROR,  8'h00, 1'b0, 8'hC0, 1'b1, 1'b0},
      '{1'b0, 1'b1, M_ROL,  8'h00, 1'b0, 8'h81, 1'b1, 1'b0},
      '{1'b0, 1'b1, M_ROL,  8'h00, 1'b1, 8'h03, 1'b1, 1'b0},  // SIN ignored
      '{1'b0, 1'b1, M_ROR,  8'h00, 1'b0, 8'h81, 1'b1, 1'b0}
    };
    for (int i = 0; i < 8; i++) begin
      drive(v[i].r, v[i].e, v[i].m, v[i].d, v[i].s);
      tests++;
      if (obs0() !== expv(v[i].q, v[i].so, v[i].co)) begin
        fails++;
        $display("FAIL shift_rotate[%0d]: got {Q,Qb,SOUT,CO,ZERO}=%h want %h",
                 i, obs0(), expv(v[i].q, v[i].so, v[i].co));
      end
    end
  endtask

  task automatic test_counter();
    vec_t v [0:9];
    v = '{
      '{1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
      '{1'b0, 1'b1, M_LOAD, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0},
      '{1'b0, 1'b1, M_SHL,  8'h00, 1'b0, 8'h00, 1'b1, 1'b0},
      '{1'b0, 1'b1, M_LOAD, 8'hFE, 1'b0, 8'hFE, 1'b1, 1'b0},
      '{1'b0, 1'b1, M_INC,  8'h00, 1'b0, 8'hFF, 1'b1, 1'b0},
      '{1'b0, 1'b1, M_INC,  8'h00, 1'b0, 8'h00, 1'b1, 1'b1},
      '{1'b0, 1'b0, M_HOLD, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1},  // EN=0 keeps CO
      '{1'b0, 1'b1, M_HOLD, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0},
      '{1'b0, 1'b1, M_DEC,  8'h00, 1'b0, 8'hFF, 1'b1, 1'b1},
      '{1'b0, 1'b1, M_DEC,  8'h00, 1'b0, 8'hFE, 1'b1, 1'b0}
    };
    for (int i = 0; i < 10; i++) begin
      drive(v[i].r, v[i].e, v[i].m, v[i].d, v[i].s);
      tests++;
      if (obs0() !== expv(v[i].q, v[i].so, v[i].co)) begin
        fails++;
        $display("FAIL counter[%0d]: got {Q,Qb,SOUT,CO,ZERO}=%h want %h",
                 i, obs0(), expv(v[i].q, v[i].so, v[i].co));
      end
    end
  endtask

  task automatic test_reset_priority();
    vec_t v [0:5];
    v = '{
      '{1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
      '{1'b0, 1'b1, M_LOAD, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0},
      '{1'b0, 1'b1, M_SHL,  8'h00, 1'b0, 8'h00, 1'b1, 1'b0},
      '{1'b0, 1'b1, M_DEC,  8'h00, 1'b0, 8'hFF, 1'b1, 1'b1},
      '{1'b1, 1'b1, M_LOAD, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b0},  // RST beats LOAD
      '{1'b1, 1'b0, M_INC,  8'h3C, 1'b1, 8'h00, 1'b0, 1'b0}   // RST beats EN=0
    };
    for (int i = 0; i < 6; i++) begin
      drive(v[i].r, v[i].e, v[i].m, v[i].d, v[i].s);
      tests++;
      if (obs0() !== expv(v[i].q, v[i].so, v[i].co)) begin
        fails++;
        $display("FAIL reset_priority[%0d]: got {Q,Qb,SOUT,CO,ZERO}=%h want %h",
                 i, obs0(), expv(v[i].q, v[i].so, v[i].co));
      end
    end
  endtask

  // Checked on dut1 (RST_VAL=0x10): reset aborts an INC run and the next
  // enabled edge counts from RST_VAL.
  task automatic test_rst_val();
    vec_t v [0:7];
    v = '{
      '{1'b1, 1'b0, M_HOLD, 8'h00, 1'b0, 8'h10, 1'b0, 1'b0},
      '{1'b0, 1'b1, M_INC,  8'h00, 1'b0, 8'h11, 1'b0, 1'b0},
      '{1'b0, 1'b1, M_INC,  8'h00, 1'b0, 8'h12, 1'b0, 1'b0},
      '{1'b0, 1'b1, M_INC,  8'h00, 1'b0, 8'h13, 1'b0, 1'b0},
      '{1'b0, 1'b1, M_INC,  8'h00, 1'b0, 8'h14, 1'b0, 1'b0},
      '{1'b1, 1'b1, M_INC,  8'h00, 1'b0, 8'h10, 1'b0, 1'b0},
      '{1'b0, 1'b1, M_INC,  8'h00, 1'b0, 8'h11, 1'b0, 1'b0},
      '{1'b0, 1'b1, M_DEC,  8'h00, 1'b0, 8'h10, 1'b0, 1'b0}
    };
    for (int i = 0; i < 8; i++) begin
      drive(v[i].r, v[i].e, v[i].m, v[i].d, v[i].s);
      tests++;
      if (obs1() !== expv(v[i].q, v[i].so, v[i].co)) begin
        fails++;
        $display("FAIL rst_val[%0d]: got {Q,Qb,SOUT,CO,ZERO}=%h want %h",
                 i, obs1(), expv(v[i].q, v[i].so, v[i].co));
      end
    end
  endtask

  // Inputs (including RST) toggled between falling edges must not touch state.
  task automatic test_between_edges();
    drive(1'b1, 1'b0, M_HOLD, 8'h00, 1'b0);
    drive(1'b0, 1'b1, M_LOAD, 8'h5A, 1'b0);
    rst  = 1'b1;
    en   = 1'b1;
    mode = M_LOAD;
    d    = 8'hFF;
    sin  = 1'b1;
    #3;
    tests++;
    if (obs0() !== expv(8'h5A, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL between_edges_rst: got %h want %h", obs0(), expv(8'h5A, 1'b0, 1'b0));
    end
    mode = M_DEC;
    rst  = 1'b0;
    #3;
    tests++;
    if (obs0() !== expv(8'h5A, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL between_edges_mode: got %h want %h", obs0(), expv(8'h5A, 1'b0, 1'b0));
    end
    drive(1'b0, 1'b1, M_INC, 8'h00, 1'b0);
    tests++;
    if (obs0() !== expv(8'h5B, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL between_edges_next: got %h want %h", obs0(), expv(8'h5B, 1'b0, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [7:0] mq;
    logic       ms, mc;
    logic       r, e, s;
    logic [2:0] m;
    logic [7:0] dd;
    int         nfail;
    nfail = 0;
    drive(1'b1, 1'b0, M_HOLD, 8'h00, 1'b0);
    mq = 8'h00;
    ms = 1'b0;
    mc = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      r  = ($urandom_range(63) == 0);
      e  = ($urandom_range(3) != 0);
      m  = 3'($urandom_range(7));
      dd = 8'($urandom);
      s  = 1'($urandom);
      if (r) begin
        mq = 8'h00; ms = 1'b0; mc = 1'b0;
      end else if (e) begin
        mc = 1'b0;
        case (m)
          M_LOAD: mq = dd;
          M_SHL:  begin ms = mq[7]; mq = (mq << 1) | {7'd0, s}; end
          M_SHR:  begin ms = mq[0]; mq = (mq >> 1) | {s, 7'd0}; end
          M_ROL:  begin ms = mq[7]; mq = (mq << 1) | (mq >> 7); end
          M_ROR:  begin ms = mq[0]; mq = (mq >> 1) | (mq << 7); end
          M_INC:  begin mc = (mq == 8'hFF); mq = mq + 8'd1; end
          M_DEC:  begin mc = (mq == 8'h00); mq = mq - 8'd1; end
          default: ;
        endcase
      end
      drive(r, e, m, dd, s);
      tests++;
      if (obs0() !== expv(mq, ms, mc) || qb0 !== ~q0) begin
        fails++;
        nfail++;
        if (nfail <= 10)
          $display("FAIL random[%0d]: got {Q,Qb,SOUT,CO,ZERO}=%h want %h",
                   i, obs0(), expv(mq, ms, mc));
      end
    end
  endtask

  initial begin
    test_reset_load_hold();
    test_shift_rotate();
    test_counter();
    test_reset_priority();
    test_rst_val();
    test_between_edges();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
